// File: rtl/lsu_ctrl_if.sv
// Core-side request/response and data-memory beat signals of the load/store unit.
// The slave modport is the LSU view; the master modport is the core and memory side.
interface lsu_ctrl_if #(
  parameter int unsigned AW    = 32,
  parameter int unsigned CNT_W = 16
);
  logic             lsu_req_valid;
  logic             lsu_req_ready;
  logic [2:0]       lsu_instr;
  logic [AW-1:0]    lsu_addr;
  logic [31:0]      lsu_wdata;
  logic             lsu_rsp_valid;
  logic [31:0]      lsu_rdata;
  logic [CNT_W-1:0] lsu_split_cnt;
  logic [AW-1:0]    mem_addr;
  logic             mem_R;
  logic             mem_W;
  logic [3:0]       mem_be;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_rdata;

  modport master (
    output lsu_req_valid, lsu_instr, lsu_addr, lsu_wdata, mem_rdata,
    input  lsu_req_ready, lsu_rsp_valid, lsu_rdata, lsu_split_cnt,
           mem_addr, mem_R, mem_W, mem_be, mem_wdata
  );

  modport slave (
    input  lsu_req_valid, lsu_instr, lsu_addr, lsu_wdata, mem_rdata,
    output lsu_req_ready, lsu_rsp_valid, lsu_rdata, lsu_split_cnt,
           mem_addr, mem_R, mem_W, mem_be, mem_wdata
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store initiator: issues word-aligned byte-enabled beats, splitting accesses
// that cross a word boundary, and returns sign/zero-extended load data.
module lsu_ctrl #(
  parameter int unsigned AW    = 32,
  parameter int unsigned CNT_W = 16
) (
  input logic       lsu_clk,
  input logic       lsu_rst_n,
  lsu_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, BEAT0, BEAT1, RDWAIT, RESP} state_t;
  typedef enum logic [2:0] {I_LW, I_LB, I_LBU, I_LH, I_LHU, I_SW, I_SB, I_SH} instr_t;

  state_t           state, state_nxt;
  instr_t           instr_q;
  logic [AW-1:0]    addr_q;
  logic [31:0]      wdata_q;
  logic [31:0]      lo_q;
  logic [31:0]      rdata_q;
  logic [CNT_W-1:0] cnt_q;

  function automatic logic [2:0] acc_size(input instr_t i);
    case (i)
      I_LW, I_SW:        acc_size = 3'd4;
      I_LH, I_LHU, I_SH: acc_size = 3'd2;
      default:           acc_size = 3'd1;
    endcase
  endfunction

  function automatic logic crosses(input instr_t i, input logic [1:0] o);
    crosses = ({2'b00, o} + {1'b0, acc_size(i)}) > 4'd4;
  endfunction

  logic          accept;
  logic [1:0]    o_q;
  logic          split_q;
  logic          load_q;
  logic [3:0]    mask;
  logic [7:0]    be_wide;
  logic [63:0]   wd_wide;
  logic [AW-1:0] w0_addr;
  logic [63:0]   rd_pair;
  logic [31:0]   rd_shift;
  logic [31:0]   rd_ext;

  assign accept  = bus.lsu_req_valid && (state == IDLE);
  assign o_q     = addr_q[1:0];
  assign split_q = crosses(instr_q, o_q);
  assign load_q  = (instr_q <= I_LHU);
  assign w0_addr = {addr_q[AW-1:2], 2'b00};

  // Shifting a double-width vector gives both beats at once: the low half is
  // beat0's lanes, the high half is what spills into the next word.
  always_comb begin
    case (acc_size(instr_q))
      3'd4:    mask = 4'hF;
      3'd2:    mask = 4'h3;
      default: mask = 4'h1;
    endcase
    be_wide = {4'b0000, mask} << o_q;
    wd_wide = {32'h0, wdata_q} << {o_q, 3'b000};
  end

  always_comb begin
    rd_pair  = split_q ? {bus.mem_rdata, lo_q} : {32'h0, bus.mem_rdata};
    rd_shift = 32'(rd_pair >> {o_q, 3'b000});
    case (instr_q)
      I_LB:    rd_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      I_LBU:   rd_ext = {24'h0, rd_shift[7:0]};
      I_LH:    rd_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
      I_LHU:   rd_ext = {16'h0, rd_shift[15:0]};
      default: rd_ext = rd_shift;
    endcase
  end

  always_ff @(posedge lsu_clk) begin
    if (!lsu_rst_n) begin
      state   <= IDLE;
      instr_q <= I_LW;
      addr_q  <= '0;
      wdata_q <= '0;
      lo_q    <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        instr_q <= instr_t'(bus.lsu_instr);
        addr_q  <= bus.lsu_addr;
        wdata_q <= bus.lsu_wdata;
        if (crosses(instr_t'(bus.lsu_instr), bus.lsu_addr[1:0]) && (cnt_q != '1))
          cnt_q <= cnt_q + CNT_W'(1);
      end
      if (state == BEAT1)
        lo_q <= bus.mem_rdata;
      if (state == RDWAIT)
        rdata_q <= rd_ext;
      else if ((state_nxt == RESP) && !load_q)
        rdata_q <= '0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.lsu_req_valid) state_nxt = BEAT0;
      BEAT0:   state_nxt = split_q ? BEAT1 : (load_q ? RDWAIT : RESP);
      BEAT1:   state_nxt = load_q ? RDWAIT : RESP;
      RDWAIT:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.lsu_req_ready = (state == IDLE);
    bus.lsu_rsp_valid = (state == RESP);
    bus.lsu_rdata     = rdata_q;
    bus.lsu_split_cnt = cnt_q;
    bus.mem_addr      = '0;
    bus.mem_R         = 1'b0;
    bus.mem_W         = 1'b0;
    bus.mem_be        = '0;
    bus.mem_wdata     = '0;
    case (state)
      BEAT0: begin
        bus.mem_addr  = w0_addr;
        bus.mem_R     = load_q;
        bus.mem_W     = !load_q;
        bus.mem_be    = be_wide[3:0];
        bus.mem_wdata = wd_wide[31:0];
      end
      BEAT1: begin
        bus.mem_addr  = w0_addr + AW'(4);
        bus.mem_R     = load_q;
        bus.mem_W     = !load_q;
        bus.mem_be    = be_wide[7:4];
        bus.mem_wdata = wd_wide[63:32];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: expected beats and responses are queued at issue
// time and a negedge monitor pops and compares them as the DUT presents them.
module tb_lsu_ctrl;

  localparam logic [2:0] LW = 3'd0, LB = 3'd1, LBU = 3'd2, LH = 3'd3, LHU = 3'd4,
                         SW = 3'd5, SB = 3'd6, SH = 3'd7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_ctrl_if #(.AW(32), .CNT_W(16)) bus ();
  lsu_ctrl #(.AW(32), .CNT_W(16)) dut (.lsu_clk(clk), .lsu_rst_n(rst_n), .bus(bus));

  lsu_ctrl_if #(.AW(32), .CNT_W(2)) sbus ();
  lsu_ctrl #(.AW(32), .CNT_W(2)) sdut (.lsu_clk(clk), .lsu_rst_n(rst_n), .bus(sbus));
  assign sbus.mem_rdata = 32'h0;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        r;
    logic        w;
    logic [31:0] wdata;
  } beat_t;

  typedef struct packed {
    logic [31:0] rdata;
    int unsigned lat;
    int unsigned acc;
  } rsp_t;

  beat_t beat_q[$];
  rsp_t  rsp_q[$];
  int checks = 0;
  int failures = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Word-organised memory with a one-cycle registered read.
  logic [31:0] mem [logic [29:0]];
  always @(posedge clk) begin
    logic [31:0] w;
    if (bus.mem_W) begin
      w = mem.exists(bus.mem_addr[31:2]) ? mem[bus.mem_addr[31:2]] : 32'h0;
      for (int i = 0; i < 4; i++)
        if (bus.mem_be[i]) w[8*i +: 8] = bus.mem_wdata[8*i +: 8];
      mem[bus.mem_addr[31:2]] = w;
    end
    if (bus.mem_R)
      bus.mem_rdata <= mem.exists(bus.mem_addr[31:2]) ? mem[bus.mem_addr[31:2]] : 32'h0;
  end

  always @(negedge clk) begin
    beat_t b;
    rsp_t  r;
    if (bus.mem_R || bus.mem_W) begin
      chk("rw_exclusive", {31'h0, bus.mem_R & bus.mem_W}, 32'h0);
      if (beat_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat: got addr 0x%08h be %b, none expected", bus.mem_addr, bus.mem_be);
      end else begin
        b = beat_q.pop_front();
        chk("beat_addr", bus.mem_addr, b.addr);
        chk("beat_be", {28'h0, bus.mem_be}, {28'h0, b.be});
        chk("beat_R", {31'h0, bus.mem_R}, {31'h0, b.r});
        chk("beat_W", {31'h0, bus.mem_W}, {31'h0, b.w});
        chk("beat_wdata", bus.mem_wdata, b.wdata);
      end
    end
    if (bus.lsu_rsp_valid) begin
      if (rsp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp: got rdata 0x%08h, none expected", bus.lsu_rdata);
      end else begin
        r = rsp_q.pop_front();
        chk("rsp_rdata", bus.lsu_rdata, r.rdata);
        chk("rsp_latency", cyc - r.acc + 1, r.lat);
      end
    end
  end

  task automatic exp_beat(input logic [31:0] addr, input logic [3:0] be,
                          input logic r, input logic [31:0] wdata);
    beat_t b;
    b.addr = addr; b.be = be; b.r = r; b.w = !r; b.wdata = wdata;
    beat_q.push_back(b);
  endtask

  // lat == 0 means no response is expected (request cut short by reset).
  task automatic issue(input logic [2:0] instr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input int unsigned lat);
    rsp_t r;
    int unsigned n = 0;
    @(negedge clk);
    while (!bus.lsu_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.lsu_req_ready) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout: got ready 0 expected 1 within 50 cycles");
    end
    bus.lsu_req_valid = 1'b1;
    bus.lsu_instr     = instr;
    bus.lsu_addr      = addr;
    bus.lsu_wdata     = wdata;
    if (lat != 0) begin
      r.rdata = exp_rdata; r.lat = lat; r.acc = cyc + 1;
      rsp_q.push_back(r);
    end
    @(posedge clk);
    #1 bus.lsu_req_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n = 0;
    while ((beat_q.size() != 0 || rsp_q.size() != 0 || !bus.lsu_req_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_beats_left", beat_q.size(), 32'h0);
    chk("drain_rsps_left", rsp_q.size(), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000 time units");
    $fatal(1);
  end

  initial begin
    int unsigned n;
    bus.lsu_req_valid = 1'b0; bus.lsu_instr = 3'd0; bus.lsu_addr = 32'h0; bus.lsu_wdata = 32'h0;
    sbus.lsu_req_valid = 1'b0; sbus.lsu_instr = 3'd0; sbus.lsu_addr = 32'h0; sbus.lsu_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'h0, bus.lsu_req_ready}, 32'h1);
    chk("rst_rsp_valid", {31'h0, bus.lsu_rsp_valid}, 32'h0);
    chk("rst_rdata", bus.lsu_rdata, 32'h0);
    chk("rst_split_cnt", {16'h0, bus.lsu_split_cnt}, 32'h0);
    chk("rst_mem_rw", {30'h0, bus.mem_R, bus.mem_W}, 32'h0);
    chk("rst_mem_be", {28'h0, bus.mem_be}, 32'h0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    rst_n = 1'b1;

    // Aligned word store and load.
    exp_beat(32'h0, 4'b1111, 1'b0, 32'h12345678);
    issue(SW, 32'h0, 32'h12345678, 32'h0, 2);
    exp_beat(32'h0, 4'b1111, 1'b1, 32'h0);
    issue(LW, 32'h0, 32'h0, 32'h12345678, 3);
    drain();
    chk("t1_split_cnt", {16'h0, bus.lsu_split_cnt}, 32'h0);

    // Byte store, signed and unsigned byte loads.
    exp_beat(32'h4, 4'b0010, 1'b0, 32'h00008000);
    issue(SB, 32'h5, 32'h80, 32'h0, 2);
    exp_beat(32'h4, 4'b0010, 1'b1, 32'h0);
    issue(LB, 32'h5, 32'h0, 32'hFFFFFF80, 3);
    exp_beat(32'h4, 4'b0010, 1'b1, 32'h0);
    issue(LBU, 32'h5, 32'h0, 32'h00000080, 3);
    drain();

    // Halfword split across 0x8/0xC.
    exp_beat(32'h8, 4'b1000, 1'b0, 32'h00000000);
    exp_beat(32'hC, 4'b0001, 1'b0, 32'h00000080);
    issue(SH, 32'hB, 32'h8000, 32'h0, 3);
    drain();
    chk("t3_split_cnt", {16'h0, bus.lsu_split_cnt}, 32'h1);
    exp_beat(32'h8, 4'b1000, 1'b1, 32'h0);
    exp_beat(32'hC, 4'b0001, 1'b1, 32'h0);
    issue(LH, 32'hB, 32'h0, 32'hFFFF8000, 4);
    exp_beat(32'h8, 4'b1000, 1'b1, 32'h0);
    exp_beat(32'hC, 4'b0001, 1'b1, 32'h0);
    issue(LHU, 32'hB, 32'h0, 32'h00008000, 4);
    drain();

    // Split word load merging two preloaded words.
    exp_beat(32'h4, 4'b1111, 1'b0, 32'hDDCCBBAA);
    issue(SW, 32'h4, 32'hDDCCBBAA, 32'h0, 2);
    exp_beat(32'h8, 4'b1111, 1'b0, 32'h44332211);
    issue(SW, 32'h8, 32'h44332211, 32'h0, 2);
    exp_beat(32'h4, 4'b1100, 1'b1, 32'h0);
    exp_beat(32'h8, 4'b0011, 1'b1, 32'h0);
    issue(LW, 32'h6, 32'h0, 32'h2211DDCC, 4);
    drain();
    chk("t4_split_cnt", {16'h0, bus.lsu_split_cnt}, 32'h4);

    // Split load wrapping past the top of the address space.
    exp_beat(32'hFFFFFFFC, 4'b1111, 1'b0, 32'hAABBCCDD);
    issue(SW, 32'hFFFFFFFC, 32'hAABBCCDD, 32'h0, 2);
    exp_beat(32'hFFFFFFFC, 4'b1100, 1'b1, 32'h0);
    exp_beat(32'h00000000, 4'b0011, 1'b1, 32'h0);
    issue(LW, 32'hFFFFFFFE, 32'h0, 32'h5678AABB, 4);
    drain();
    chk("t5_split_cnt", {16'h0, bus.lsu_split_cnt}, 32'h5);

    // Saturation on a narrow-counter instance: 3 is all-ones.
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      n = 0;
      while (!sbus.lsu_req_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("sat_ready", {31'h0, sbus.lsu_req_ready}, 32'h1);
      sbus.lsu_req_valid = 1'b1;
      sbus.lsu_instr     = SH;
      sbus.lsu_addr      = 32'hB;
      sbus.lsu_wdata     = 32'h1234;
      @(posedge clk);
      #1 sbus.lsu_req_valid = 1'b0;
      @(negedge clk);
      chk("sat_split_cnt", {30'h0, sbus.lsu_split_cnt}, (i > 3) ? 32'd3 : 32'(i));
    end

    // Reset during the second beat of a split store.
    exp_beat(32'h10, 4'b1110, 1'b0, 32'hFEF00D00);
    exp_beat(32'h14, 4'b0001, 1'b0, 32'h000000CA);
    issue(SW, 32'h11, 32'hCAFEF00D, 32'h0, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_mem_W", {31'h0, bus.mem_W}, 32'h0);
    chk("t6_ready", {31'h0, bus.lsu_req_ready}, 32'h1);
    chk("t6_rsp_valid", {31'h0, bus.lsu_rsp_valid}, 32'h0);
    chk("t6_split_cnt", {16'h0, bus.lsu_split_cnt}, 32'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_no_late_rsp", {31'h0, bus.lsu_rsp_valid}, 32'h0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
